// File: rtl/prog_loader_if.sv
// Loader-facing bundle: load command, incoming byte stream, RAM write port and CPU control.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              load_req;
  logic [ADDR_W-1:0] start_addr;
  logic [8:0]        len;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] start_pc;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_req, start_addr, len, in_valid, in_byte,
    input  in_ready, ram_w_en, ram_w_addr, ram_w_data, cpu_rst_n, start_pc, busy, done, err
  );

  modport slave (
    input  load_req, start_addr, len, in_valid, in_byte,
    output in_ready, ram_w_en, ram_w_addr, ram_w_data, cpu_rst_n, start_pc, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Packs a byte stream big-endian into 16-bit words, writes them to CPU RAM from a base
// address and holds the CPU in reset until the whole program has landed.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        count;
  logic [7:0]        hi_byte, lo_byte;
  logic              load_ok, load_bad;
  logic              cpu_rst_n_q, done_q, err_q;
  logic [ADDR_W-1:0] start_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_ok   = 1'b0;
    load_bad  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.load_req) begin
          if (bus.len == 9'd0 || bus.len > 9'd256) begin
            load_bad = 1'b1;
          end else begin
            load_ok   = 1'b1;
            state_nxt = HI;
          end
        end
      end
      HI:      if (bus.in_valid) state_nxt = LO;
      LO:      if (bus.in_valid) state_nxt = WRITE;
      WRITE:   state_nxt = (count == 9'd1) ? DONE : HI;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; a reset mid-load drops any half-built word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      count       <= '0;
      hi_byte     <= '0;
      lo_byte     <= '0;
      start_pc_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (load_ok) begin
        ptr        <= bus.start_addr;
        start_pc_q <= bus.start_addr;
        count      <= bus.len;
      end
      if (state == HI && bus.in_valid) hi_byte <= bus.in_byte;
      if (state == LO && bus.in_valid) lo_byte <= bus.in_byte;
      if (state == WRITE) begin
        ptr   <= ptr + 1'b1;
        count <= count - 9'd1;
      end
      err_q       <= load_bad;
      done_q      <= (state_nxt == DONE);
      cpu_rst_n_q <= (state_nxt == DONE);
    end
  end

  assign bus.in_ready   = (state == HI) || (state == LO);
  assign bus.busy       = (state == HI) || (state == LO) || (state == WRITE);
  assign bus.ram_w_en   = (state == WRITE);
  assign bus.ram_w_addr = (state == WRITE) ? ptr : '0;
  assign bus.ram_w_data = (state == WRITE) ? DATA_W'({hi_byte, lo_byte}) : '0;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.start_pc   = start_pc_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: captures RAM writes and compares against hand-computed words.
module tb_prog_loader;
  logic gclk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;
  int   err_cnt = 0;
  int   rdy_viol = 0;
  logic [15:0] mem [256];

  prog_loader_if bus ();
  prog_loader dut (.clk(gclk), .rst_n(rst_n), .bus(bus));

  always #5 gclk = ~gclk;

  always @(posedge gclk) begin
    if (bus.ram_w_en) begin
      mem[bus.ram_w_addr] = bus.ram_w_data;
      wr_cnt++;
      if (bus.in_ready) rdy_viol++;
    end
    if (bus.err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
  endtask

  task automatic start_load(input logic [7:0] a, input logic [8:0] l);
    bus.load_req = 1'b1; bus.start_addr = a; bus.len = l;
    @(negedge gclk);
    bus.load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge gclk);
    bus.in_valid = 1'b1; bus.in_byte = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge gclk); n++; end
    if (n >= 50) chk("rdy_tmo", 32'd0, 32'd1);
    @(negedge gclk);
    bus.in_valid = 1'b0; bus.in_byte = 8'hxx;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 200) begin @(negedge gclk); n++; end
    if (n >= 200) chk("done_tmo", 32'd0, 32'd1);
  endtask

  initial begin
    int w0, e0;
    logic [7:0] pat [8];
    pat[0] = 8'h01; pat[1] = 8'h23; pat[2] = 8'h45; pat[3] = 8'h67;
    pat[4] = 8'h89; pat[5] = 8'hAB; pat[6] = 8'hCD; pat[7] = 8'hEF;
    bus.load_req = 1'b0; bus.start_addr = '0; bus.len = '0;
    bus.in_valid = 1'b0; bus.in_byte = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wen",   32'(bus.ram_w_en), 32'd0);
    chk("rst_waddr", 32'(bus.ram_w_addr), 32'd0);
    chk("rst_wdata", 32'(bus.ram_w_data), 32'd0);
    chk("rst_cpu",   32'(bus.cpu_rst_n), 32'd0);
    chk("rst_pc",    32'(bus.start_pc), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_err",   32'(bus.err), 32'd0);
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);

    // 1: basic two-word load
    w0 = wr_cnt;
    start_load(8'h10, 9'd2);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_cpu_held", 32'(bus.cpu_rst_n), 32'd0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0);
    send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    wait_done();
    chk("t1_w0", 32'(mem[8'h10]), 32'hA1B2);
    chk("t1_w1", 32'(mem[8'h11]), 32'hC3D4);
    chk("t1_nwr", 32'(wr_cnt - w0), 32'd2);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_cpu", 32'(bus.cpu_rst_n), 32'd1);
    chk("t1_pc", 32'(bus.start_pc), 32'h10);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);

    // 2: address wrap 0xFF -> 0x00
    e0 = err_cnt;
    start_load(8'hFF, 9'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    wait_done();
    chk("t2_wff", 32'(mem[8'hFF]), 32'h1122);
    chk("t2_w00", 32'(mem[8'h00]), 32'h3344);
    chk("t2_noerr", 32'(err_cnt - e0), 32'd0);
    chk("t2_pc", 32'(bus.start_pc), 32'hFF);

    // 3: illegal lengths in IDLE
    do_reset();
    w0 = wr_cnt; e0 = err_cnt;
    start_load(8'h30, 9'd0);
    chk("t3_err0", 32'(bus.err), 32'd1);
    @(negedge gclk);
    chk("t3_err0_clr", 32'(bus.err), 32'd0);
    chk("t3_idle0", 32'(bus.busy), 32'd0);
    start_load(8'h30, 9'd257);
    chk("t3_err257", 32'(bus.err), 32'd1);
    @(negedge gclk);
    chk("t3_err257_clr", 32'(bus.err), 32'd0);
    chk("t3_idle257", 32'(bus.busy), 32'd0);
    chk("t3_nerr", 32'(err_cnt - e0), 32'd2);
    chk("t3_nwr", 32'(wr_cnt - w0), 32'd0);
    chk("t3_done", 32'(bus.done), 32'd0);

    // 4: gap-free then gappy len=4 loads must give the same words
    rdy_viol = 0;
    start_load(8'h20, 9'd4);
    for (int i = 0; i < 8; i++) send_byte(pat[i], 0);
    wait_done();
    start_load(8'h40, 9'd4);
    for (int i = 0; i < 8; i++) send_byte(pat[i], int'($urandom_range(0, 5)));
    wait_done();
    chk("t4_a0", 32'(mem[8'h20]), 32'h0123);
    chk("t4_a3", 32'(mem[8'h23]), 32'hCDEF);
    chk("t4_b0", 32'(mem[8'h40]), 32'h0123);
    chk("t4_b1", 32'(mem[8'h41]), 32'h4567);
    chk("t4_b2", 32'(mem[8'h42]), 32'h89AB);
    chk("t4_b3", 32'(mem[8'h43]), 32'hCDEF);
    chk("t4_rdy_in_write", 32'(rdy_viol), 32'd0);

    // 5: reset after the third byte of a len=3 load
    w0 = wr_cnt;
    start_load(8'h80, 9'd3);
    send_byte(8'h5A, 0); send_byte(8'hA5, 0); send_byte(8'h77, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_nwr", 32'(wr_cnt - w0), 32'd1);
    chk("t5_word", 32'(mem[8'h80]), 32'h5AA5);
    chk("t5_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_cpu", 32'(bus.cpu_rst_n), 32'd0);
    chk("t5_pc", 32'(bus.start_pc), 32'd0);
    chk("t5_wen", 32'(bus.ram_w_en), 32'd0);
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    start_load(8'h90, 9'd1);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    wait_done();
    chk("t5_reload", 32'(mem[8'h90]), 32'hBEEF);
    chk("t5_pc2", 32'(bus.start_pc), 32'h90);

    // 6: reload from DONE
    w0 = wr_cnt;
    start_load(8'h05, 9'd1);
    chk("t6_cpu_drop", 32'(bus.cpu_rst_n), 32'd0);
    chk("t6_done_clr", 32'(bus.done), 32'd0);
    chk("t6_pc", 32'(bus.start_pc), 32'h05);
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    wait_done();
    chk("t6_word", 32'(mem[8'h05]), 32'h1234);
    chk("t6_nwr", 32'(wr_cnt - w0), 32'd1);
    chk("t6_cpu", 32'(bus.cpu_rst_n), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
